// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC rotator and its request scheduler.
// All data values are signed Q16.16.
package cordic_pkg;

  localparam int CORDIC_DW   = 32;
  localparam int CORDIC_LAT  = 17;
  localparam int CORDIC_FRAC = 16;

  // 1/gain pre-scale and pi/4, both in Q16.16
  localparam logic signed [31:0] K_Q16   = 32'sd39797;
  localparam logic signed [31:0] PI4_Q16 = 32'sd51471;

  // Tag field is sized for the largest supported requester count (8)
  localparam int MAX_NREQ  = 8;
  localparam int TAG_MAX_W = $clog2(MAX_NREQ);

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Requester, core and response signals of the CORDIC scheduler.
// The scheduler is the slave; clients and core model sit on the master side.
interface cordic_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_x;
  logic [NREQ*DW-1:0] req_y;
  logic [NREQ*DW-1:0] req_z;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      core_x0;
  logic [DW-1:0]      core_y0;
  logic [DW-1:0]      core_z0;
  logic [DW-1:0]      core_X;
  logic [DW-1:0]      core_Y;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_x;
  logic [DW-1:0]      rsp_y;
  logic               busy;

  modport master (
    output req, req_x, req_y, req_z, core_X, core_Y,
    input  gnt, core_x0, core_y0, core_z0, rsp_valid, rsp_x, rsp_y, busy
  );

  modport slave (
    input  req, req_x, req_y, req_z, core_X, core_Y,
    output gnt, core_x0, core_y0, core_z0, rsp_valid, rsp_x, rsp_y, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// after the last-granted index (ptr), wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int TAG_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [TAG_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [TAG_W-1:0] idx
);

  logic             found;
  logic [TAG_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = TAG_W'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one fixed-latency CORDIC rotator between NREQ requesters: one issue per
// cycle, a tag/valid pipe steers each result back to the requester that issued it.
module cordic_rr_scheduler
  import cordic_pkg::*;
#(
  parameter int  NREQ     = 4,
  parameter int  DW       = CORDIC_DW,
  parameter int  CORE_LAT = CORDIC_LAT,
  localparam int TAG_W    = $clog2(NREQ)
) (
  input logic                  clk,
  input logic                  rst,
  cordic_rr_scheduler_if.slave bus
);

  logic [NREQ-1:0]  arb_gnt;
  logic [NREQ-1:0]  gnt;
  logic [TAG_W-1:0] arb_idx;
  logic             issue;
  logic             busy;

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [DW-1:0]    core_x0_q, core_x0_d;
  logic [DW-1:0]    core_y0_q, core_y0_d;
  logic [DW-1:0]    core_z0_q, core_z0_d;

  // One entry per cycle of flight; the last stage lines up with the core output
  tag_entry_t tag_pipe_q [CORE_LAT+1];
  tag_entry_t tag_pipe_d [CORE_LAT+1];

  rr_arbiter #(
    .NREQ  (NREQ),
    .TAG_W (TAG_W)
  ) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Reset suppresses any grant in the same cycle
  always_comb begin
    gnt       = rst ? '0 : arb_gnt;
    issue     = |gnt;
    ptr_d     = issue ? arb_idx : ptr_q;
    core_x0_d = issue ? bus.req_x[arb_idx*DW +: DW] : core_x0_q;
    core_y0_d = issue ? bus.req_y[arb_idx*DW +: DW] : core_y0_q;
    core_z0_d = issue ? bus.req_z[arb_idx*DW +: DW] : core_z0_q;
    tag_pipe_d[0].valid = issue;
    tag_pipe_d[0].tag   = TAG_MAX_W'(arb_idx);
    for (int i = 1; i <= CORE_LAT; i++) begin
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= CORE_LAT; i++) begin
      busy = busy | tag_pipe_q[i].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= TAG_W'(NREQ - 1);
      core_x0_q <= '0;
      core_y0_q <= '0;
      core_z0_q <= '0;
      for (int i = 0; i <= CORE_LAT; i++) begin
        tag_pipe_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      core_x0_q <= core_x0_d;
      core_y0_q <= core_y0_d;
      core_z0_q <= core_z0_d;
      for (int i = 0; i <= CORE_LAT; i++) begin
        tag_pipe_q[i] <= tag_pipe_d[i];
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.core_x0   = core_x0_q;
  assign bus.core_y0   = core_y0_q;
  assign bus.core_z0   = core_z0_q;
  assign bus.rsp_valid = tag_pipe_q[CORE_LAT].valid ?
                         (NREQ'(1) << tag_pipe_q[CORE_LAT].tag) : '0;
  assign bus.rsp_x     = bus.core_X;
  assign bus.rsp_y     = bus.core_Y;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: an ideal-rotation core model with a fixed delay
// line, a transaction scoreboard for grants/responses, directed and random traffic.
module tb_cordic_rr_scheduler;
  import cordic_pkg::*;

  localparam int  NREQ      = 4;
  localparam int  DW        = CORDIC_DW;
  localparam int  LAT       = CORDIC_LAT;
  localparam int  RSP_DELAY = LAT + 1;
  localparam real GAIN      = 1.6467602581210656;

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;
  bit checking     = 1'b0;

  logic [NREQ-1:0] gnt_seen = '0;
  rsp_t            exp_q[$];
  int              model_ptr = NREQ - 1;
  logic [DW-1:0]   model_x0 = '0;
  logic [DW-1:0]   model_y0 = '0;
  logic [DW-1:0]   model_z0 = '0;
  logic [DW-1:0]   core_pipe_x [LAT];
  logic [DW-1:0]   core_pipe_y [LAT];

  cordic_rr_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

  cordic_rr_scheduler #(
    .NREQ     (NREQ),
    .DW       (DW),
    .CORE_LAT (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Ideal rotation including the CORDIC gain, rounded to Q16.16
  function automatic logic [DW-1:0] rotate(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input logic [DW-1:0] z, input bit want_y);
    real scale, xr, yr, ang, r;
    scale = $itor(1 << CORDIC_FRAC);
    xr    = $itor($signed(x));
    yr    = $itor($signed(y));
    ang   = $itor($signed(z)) / scale;
    if (want_y) r = GAIN * (xr * $sin(ang) + yr * $cos(ang));
    else        r = GAIN * (xr * $cos(ang) - yr * $sin(ang));
    return DW'(longint'(r));
  endfunction

  // Core model: input stable in cycle c, result on core_X/core_Y in cycle c+LAT
  always @(posedge clk) begin
    core_pipe_x[0] <= rotate(bus.core_x0, bus.core_y0, bus.core_z0, 1'b0);
    core_pipe_y[0] <= rotate(bus.core_x0, bus.core_y0, bus.core_z0, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      core_pipe_x[i] <= core_pipe_x[i-1];
      core_pipe_y[i] <= core_pipe_y[i-1];
    end
  end

  assign bus.core_X = core_pipe_x[LAT-1];
  assign bus.core_Y = core_pipe_y[LAT-1];

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected, input int tol = 0);
    longint diff;
    tests_run++;
    diff = longint'($signed(observed)) - longint'($signed(expected));
    if ((^observed === 1'bx) || diff > tol || diff < -tol) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h) +/-%0d at cycle %0d",
               tag, $signed(observed), observed, $signed(expected), expected, tol, cycle);
    end
  endtask

  // Scoreboard: every cycle predict grant, operand registers, busy and responses
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] exp_rsp;
    rsp_t            e;
    int              g;
    int              k;
    cycle++;
    gnt_seen = bus.gnt;
    if (checking) begin
      checkOutput("busy", DW'(bus.busy), DW'(exp_q.size() != 0));
      exp_rsp = '0;
      if (exp_q.size() != 0 && exp_q[0].due == cycle) begin
        exp_rsp = NREQ'(1) << exp_q[0].idx;
        checkOutput("rsp_x", bus.rsp_x, exp_q[0].x);
        checkOutput("rsp_y", bus.rsp_y, exp_q[0].y);
        void'(exp_q.pop_front());
      end
      checkOutput("rsp_valid", DW'(bus.rsp_valid), DW'(exp_rsp));
      checkOutput("core_x0", bus.core_x0, model_x0);
      checkOutput("core_y0", bus.core_y0, model_y0);
      checkOutput("core_z0", bus.core_z0, model_z0);

      g = -1;
      if (!rst) begin
        for (int i = 1; i <= NREQ; i++) begin
          k = (model_ptr + i) % NREQ;
          if (g < 0 && bus.req[k] === 1'b1) g = k;
        end
      end
      exp_gnt = (g >= 0) ? (NREQ'(1) << g) : '0;
      checkOutput("gnt", DW'(bus.gnt), DW'(exp_gnt));

      if (g >= 0) begin
        model_ptr = g;
        model_x0  = bus.req_x[g*DW +: DW];
        model_y0  = bus.req_y[g*DW +: DW];
        model_z0  = bus.req_z[g*DW +: DW];
        e.due     = cycle + RSP_DELAY;
        e.idx     = g;
        e.x       = rotate(model_x0, model_y0, model_z0, 1'b0);
        e.y       = rotate(model_x0, model_y0, model_z0, 1'b1);
        exp_q.push_back(e);
      end
      if (rst) begin
        exp_q.delete();
        model_ptr = NREQ - 1;
        model_x0  = '0;
        model_y0  = '0;
        model_z0  = '0;
      end
    end
  end

  task automatic setOperands(input int k, input logic [DW-1:0] x, input logic [DW-1:0] y,
                             input logic [DW-1:0] z);
    bus.req_x[k*DW +: DW] = x;
    bus.req_y[k*DW +: DW] = y;
    bus.req_z[k*DW +: DW] = z;
  endtask

  // Raise one request, hold it until granted, then drop it
  task automatic applyStimulus(input int k, input logic [DW-1:0] x, input logic [DW-1:0] y,
                               input logic [DW-1:0] z);
    int n = 0;
    @(posedge clk); #1;
    setOperands(k, x, y, z);
    bus.req[k] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt[k] !== 1'b1 && n < 20);
    checkOutput("grant_wait", DW'(bus.gnt[k]), DW'(1));
    @(posedge clk); #1;
    bus.req[k] = 1'b0;
  endtask

  // Called right after applyStimulus: the response is due RSP_DELAY cycles after grant
  task automatic awaitResponse(input int k, input logic [DW-1:0] ex, input logic [DW-1:0] ey);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rsp_valid[k] !== 1'b1 && n < 40);
    checkOutput("rsp_latency", DW'(n), DW'(RSP_DELAY));
    checkOutput("rsp_strobe", DW'(bus.rsp_valid), DW'(NREQ'(1) << k));
    checkOutput("rsp_x_value", bus.rsp_x, ex, 8);
    checkOutput("rsp_y_value", bus.rsp_y, ey, 8);
  endtask

  task automatic runRandom(input int ncycles, input int density);
    int v;
    for (int c = 0; c < ncycles; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req[k] && !gnt_seen[k]) begin
          if ($urandom_range(0, 15) == 0) bus.req[k] = 1'b0;
        end else begin
          bus.req[k] = (int'($urandom_range(0, 99)) < density);
          v = int'($urandom_range(0, 80000)) - 40000;
          bus.req_x[k*DW +: DW] = DW'(v);
          v = int'($urandom_range(0, 80000)) - 40000;
          bus.req_y[k*DW +: DW] = DW'(v);
          v = int'($urandom_range(0, 4 * PI4_Q16)) - 2 * PI4_Q16;
          bus.req_z[k*DW +: DW] = DW'(v);
        end
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    bus.req   = '1;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_z = '0;
    rst       = 1'b1;

    // Reset with every request raised: grant must stay low
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_gnt", DW'(bus.gnt), DW'(0));
    end
    @(posedge clk); #1;
    rst      = 1'b0;
    bus.req  = '0;
    checking = 1'b1;
    @(negedge clk);
    checkOutput("reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    checkOutput("reset_busy", DW'(bus.busy), DW'(0));
    checkOutput("reset_core_x0", bus.core_x0, DW'(0));
    checkOutput("reset_core_y0", bus.core_y0, DW'(0));
    checkOutput("reset_core_z0", bus.core_z0, DW'(0));

    // All four requesting for 8 cycles, distinct angles per requester
    @(posedge clk); #1;
    for (int k = 0; k < NREQ; k++) begin
      setOperands(k, K_Q16 + DW'(k * 100), DW'(k * 1000), DW'((k - 1) * PI4_Q16));
    end
    bus.req = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("rr_order", DW'(bus.gnt), DW'(NREQ'(1) << (i % NREQ)));
    end
    @(posedge clk); #1;
    bus.req = '0;
    repeat (RSP_DELAY + 8) @(negedge clk);

    // Single requesters with known results
    applyStimulus(0, K_Q16, DW'(0), DW'(0));
    awaitResponse(0, DW'(65536), DW'(0));
    applyStimulus(2, K_Q16, DW'(0), PI4_Q16);
    awaitResponse(2, DW'(46341), DW'(46341));

    // Reset while req1 is in flight; req2 raised during reset
    applyStimulus(1, K_Q16, DW'(0), PI4_Q16);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    setOperands(2, DW'(1234), DW'(5678), DW'(0));
    bus.req[2] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_wins_gnt", DW'(bus.gnt), DW'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_rst", DW'(bus.busy), DW'(0));
    checkOutput("gnt_after_rst", DW'(bus.gnt), DW'(4'b0100));
    @(posedge clk); #1;
    bus.req[2] = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid[1] === 1'b1) cnt++;
    end
    checkOutput("req1_flushed", DW'(cnt), DW'(0));

    // Requester 3 held for 20 cycles: granted every cycle, 20 strobes back
    @(posedge clk); #1;
    setOperands(3, DW'(20000), DW'(-30000), DW'(-PI4_Q16));
    bus.req[3] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i < 20) checkOutput("req3_streak", DW'(bus.gnt), DW'(4'b1000));
      if (bus.rsp_valid === 4'b1000) cnt++;
      if (i == 19) begin
        @(posedge clk); #1;
        bus.req[3] = 1'b0;
      end
    end
    checkOutput("req3_strobes", DW'(cnt), DW'(20));

    // Random traffic at two loads, with occasional reset pulses and withdrawals
    runRandom(300, 35);
    runRandom(300, 80);
    bus.req = '0;
    repeat (RSP_DELAY + 5) @(negedge clk);
    checkOutput("drain_busy", DW'(bus.busy), DW'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
